// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone target among ITR_CNT initiators.
// Grant is registered; target signals are an AND-OR mux of the granted initiator.
module wb_arbiter #(
    parameter int ITR_CNT    = 4,
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int TGWD_WIDTH = 1,
    parameter int MAX_OUT    = 4
) (
    input  logic                            clk_i,
    input  logic                            async_rst_i,
    input  logic                            sync_rst_i,
    input  logic [ITR_CNT-1:0]              itr_cyc_i,
    input  logic [ITR_CNT-1:0]              itr_stb_i,
    input  logic [ITR_CNT-1:0]              itr_we_i,
    input  logic [ITR_CNT-1:0]              itr_lock_i,
    input  logic [ITR_CNT*SEL_WIDTH-1:0]    itr_sel_i,
    input  logic [ITR_CNT*ADR_WIDTH-1:0]    itr_adr_i,
    input  logic [ITR_CNT*DAT_WIDTH-1:0]    itr_dat_i,
    input  logic [ITR_CNT*TGA_WIDTH-1:0]    itr_tga_i,
    input  logic [ITR_CNT*TGC_WIDTH-1:0]    itr_tgc_i,
    input  logic [ITR_CNT*TGWD_WIDTH-1:0]   itr_tgd_i,
    output logic [ITR_CNT-1:0]              itr_ack_o,
    output logic [ITR_CNT-1:0]              itr_err_o,
    output logic [ITR_CNT-1:0]              itr_rty_o,
    output logic [ITR_CNT-1:0]              itr_stall_o,
    output logic [DAT_WIDTH-1:0]            itr_dat_o,
    output logic [TGRD_WIDTH-1:0]           itr_tgd_o,
    output logic                            tgt_cyc_o,
    output logic                            tgt_stb_o,
    output logic                            tgt_we_o,
    output logic                            tgt_lock_o,
    output logic [SEL_WIDTH-1:0]            tgt_sel_o,
    output logic [ADR_WIDTH-1:0]            tgt_adr_o,
    output logic [DAT_WIDTH-1:0]            tgt_dat_o,
    output logic [TGA_WIDTH-1:0]            tgt_tga_o,
    output logic [TGC_WIDTH-1:0]            tgt_tgc_o,
    output logic [TGWD_WIDTH-1:0]           tgt_tgd_o,
    input  logic                            tgt_ack_i,
    input  logic                            tgt_err_i,
    input  logic                            tgt_rty_i,
    input  logic                            tgt_stall_i,
    input  logic [DAT_WIDTH-1:0]            tgt_dat_i,
    input  logic [TGRD_WIDTH-1:0]           tgt_tgd_i,
    output logic [ITR_CNT-1:0]              gnt_o
);

    localparam int IDX_W = (ITR_CNT > 1) ? $clog2(ITR_CNT) : 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(ITR_CNT - 1);
    localparam logic [ITR_CNT-1:0] ONE_HOT0 = {{(ITR_CNT-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    logic [ITR_CNT-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    state_e             state_s;
    logic               sel_cyc_s, sel_lock_s, sel_stb_s;
    logic               full_s, accept_s, resp_s, found_s;
    logic [IDX_W-1:0]   pick_s;

    // Grant register, round-robin pointer and outstanding-access counter
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            gnt_q <= '0;
            ptr_q <= PTR_RST;
            cnt_q <= '0;
        end else if (sync_rst_i) begin
            gnt_q <= '0;
            ptr_q <= PTR_RST;
            cnt_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // AND-OR mux of the granted initiator onto the target
    always_comb begin
        tgt_sel_o = '0;
        tgt_adr_o = '0;
        tgt_dat_o = '0;
        tgt_tga_o = '0;
        tgt_tgc_o = '0;
        tgt_tgd_o = '0;
        for (int i = 0; i < ITR_CNT; i++) begin
            tgt_sel_o = tgt_sel_o | (itr_sel_i[i*SEL_WIDTH +: SEL_WIDTH]   & {SEL_WIDTH{gnt_q[i]}});
            tgt_adr_o = tgt_adr_o | (itr_adr_i[i*ADR_WIDTH +: ADR_WIDTH]   & {ADR_WIDTH{gnt_q[i]}});
            tgt_dat_o = tgt_dat_o | (itr_dat_i[i*DAT_WIDTH +: DAT_WIDTH]   & {DAT_WIDTH{gnt_q[i]}});
            tgt_tga_o = tgt_tga_o | (itr_tga_i[i*TGA_WIDTH +: TGA_WIDTH]   & {TGA_WIDTH{gnt_q[i]}});
            tgt_tgc_o = tgt_tgc_o | (itr_tgc_i[i*TGC_WIDTH +: TGC_WIDTH]   & {TGC_WIDTH{gnt_q[i]}});
            tgt_tgd_o = tgt_tgd_o | (itr_tgd_i[i*TGWD_WIDTH +: TGWD_WIDTH] & {TGWD_WIDTH{gnt_q[i]}});
        end
    end

    assign state_s    = (gnt_q == '0) ? ST_IDLE : ST_BUSY;
    assign sel_cyc_s  = |(gnt_q & itr_cyc_i);
    assign sel_lock_s = |(gnt_q & itr_lock_i);
    assign sel_stb_s  = |(gnt_q & itr_stb_i);
    assign full_s     = (cnt_q == MAX_CNT);

    assign tgt_cyc_o  = sel_cyc_s;
    assign tgt_lock_o = sel_lock_s;
    assign tgt_we_o   = |(gnt_q & itr_we_i);
    assign tgt_stb_o  = sel_stb_s & ~full_s;

    assign accept_s   = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i;
    assign resp_s     = tgt_ack_i | tgt_err_i | tgt_rty_i;

    assign itr_ack_o  = gnt_q & {ITR_CNT{tgt_ack_i}};
    assign itr_err_o  = gnt_q & {ITR_CNT{tgt_err_i}};
    assign itr_rty_o  = gnt_q & {ITR_CNT{tgt_rty_i}};
    assign itr_stall_o = ~gnt_q | {ITR_CNT{tgt_stall_i | full_s}};
    assign itr_dat_o  = tgt_dat_i;
    assign itr_tgd_o  = tgt_tgd_i;
    assign gnt_o      = gnt_q;

    // First requester after the pointer; while busy the pointer equals the grant,
    // so the releasing initiator (cyc low) is naturally searched last
    always_comb begin
        int idx;
        found_s = 1'b0;
        pick_s  = '0;
        for (int k = 1; k <= ITR_CNT; k++) begin
            idx = (int'(ptr_q) + k) % ITR_CNT;
            if (!found_s && itr_cyc_i[idx]) begin
                found_s = 1'b1;
                pick_s  = IDX_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next grant, pointer and outstanding count
    always_comb begin
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        case (state_s)
            ST_IDLE: begin
                cnt_d = '0;
                if (found_s) begin
                    gnt_d = ONE_HOT0 << pick_s;
                    ptr_d = pick_s;
                end else begin
                    gnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (!sel_cyc_s && !sel_lock_s) begin
                    cnt_d = '0;
                    if (found_s) begin
                        gnt_d = ONE_HOT0 << pick_s;
                        ptr_d = pick_s;
                    end else begin
                        gnt_d = '0;
                    end
                end else if (!sel_cyc_s) begin
                    // locked gap or aborted cycle: outstanding accesses are forgotten
                    cnt_d = '0;
                end else if (accept_s && !resp_s && !full_s) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (resp_s && !accept_s && (cnt_q != 4'd0)) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                gnt_d = '0;
                ptr_d = PTR_RST;
                cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized bench for wb_arbiter against a cycle-level behavioural model.
module tb_wb_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic async_rst, sync_rst;
    logic [N-1:0] cyc, stb, we, lock;
    logic [N*2-1:0] sel;
    logic [N*AW-1:0] adr;
    logic [N*DW-1:0] dat;
    logic [N-1:0] tga, tgc, tgd;
    logic tack, terr, trty, tstall;
    logic [DW-1:0] tdat;
    logic [0:0] ttgd;

    logic [N-1:0] ack_o, err_o, rty_o, stall_o, gnt_o;
    logic [DW-1:0] idat_o;
    logic [0:0] itgd_o;
    logic t_cyc, t_stb, t_we, t_lock;
    logic [1:0] t_sel;
    logic [AW-1:0] t_adr;
    logic [DW-1:0] t_dat;
    logic [0:0] t_tga, t_tgc, t_tgd;

    int checks = 0;
    int failures = 0;

    // behavioural model: granted index (-1 = none), priority pointer, outstanding count
    int mg, mptr, mcnt;
    logic smp_cyc, smp_stb, smp_lock, smp_acc;
    logic [N-1:0] smp_stall, smp_ack, smp_err;

    wb_arbiter dut (
        .clk_i(clk), .async_rst_i(async_rst), .sync_rst_i(sync_rst),
        .itr_cyc_i(cyc), .itr_stb_i(stb), .itr_we_i(we), .itr_lock_i(lock),
        .itr_sel_i(sel), .itr_adr_i(adr), .itr_dat_i(dat),
        .itr_tga_i(tga), .itr_tgc_i(tgc), .itr_tgd_i(tgd),
        .itr_ack_o(ack_o), .itr_err_o(err_o), .itr_rty_o(rty_o), .itr_stall_o(stall_o),
        .itr_dat_o(idat_o), .itr_tgd_o(itgd_o),
        .tgt_cyc_o(t_cyc), .tgt_stb_o(t_stb), .tgt_we_o(t_we), .tgt_lock_o(t_lock),
        .tgt_sel_o(t_sel), .tgt_adr_o(t_adr), .tgt_dat_o(t_dat),
        .tgt_tga_o(t_tga), .tgt_tgc_o(t_tgc), .tgt_tgd_o(t_tgd),
        .tgt_ack_i(tack), .tgt_err_i(terr), .tgt_rty_i(trty), .tgt_stall_i(tstall),
        .tgt_dat_i(tdat), .tgt_tgd_i(ttgd),
        .gnt_o(gnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mg = -1;
        mptr = N - 1;
        mcnt = 0;
    endtask

    task automatic clear_inputs();
        cyc = '0; stb = '0; we = '0; lock = '0;
        tack = 1'b0; terr = 1'b0; trty = 1'b0; tstall = 1'b0;
    endtask

    // compare one cycle at the falling edge, then advance the model at the rising edge
    task automatic cycle();
        logic e_cyc, e_stb, e_lock, acc, rsp;
        logic [N-1:0] e_stall;
        int nxt, idx, g;
        @(negedge clk);
        g = mg;
        e_cyc  = (g >= 0) && cyc[g];
        e_lock = (g >= 0) && lock[g];
        e_stb  = (g >= 0) && stb[g] && (mcnt != MAX);
        for (int i = 0; i < N; i++) e_stall[i] = (i == g) ? (tstall || mcnt == MAX) : 1'b1;
        chk("gnt", gnt_o, (g < 0) ? 0 : (1 << g));
        chk("tgt_cyc", t_cyc, e_cyc);
        chk("tgt_stb", t_stb, e_stb);
        chk("tgt_lock", t_lock, e_lock);
        chk("tgt_we", t_we, (g >= 0) ? we[g] : 1'b0);
        chk("tgt_adr", t_adr, (g >= 0) ? adr[g*AW +: AW] : 16'h0);
        chk("tgt_dat", t_dat, (g >= 0) ? dat[g*DW +: DW] : 16'h0);
        chk("tgt_sel", t_sel, (g >= 0) ? sel[g*2 +: 2] : 2'b0);
        chk("stall", stall_o, e_stall);
        chk("ack", ack_o, (g >= 0) ? (tack << g) : 0);
        chk("err", err_o, (g >= 0) ? (terr << g) : 0);
        chk("rty", rty_o, (g >= 0) ? (trty << g) : 0);
        chk("rdat", idat_o, tdat);
        acc = e_cyc && e_stb && !tstall;
        rsp = tack || terr || trty;
        smp_cyc = t_cyc; smp_stb = t_stb; smp_lock = t_lock;
        smp_stall = stall_o; smp_ack = ack_o; smp_err = err_o;
        smp_acc = t_cyc & t_stb & ~tstall;
        @(posedge clk);
        if (sync_rst) begin
            model_reset();
        end else if (g < 0 || (!cyc[g] && !lock[g])) begin
            mcnt = 0;
            nxt = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (mptr + k) % N;
                if (nxt < 0 && cyc[idx]) nxt = idx;
            end
            mg = nxt;
            if (nxt >= 0) mptr = nxt;
        end else if (!cyc[g]) begin
            mcnt = 0;
        end else begin
            mcnt = mcnt + (acc ? 1 : 0) - (rsp ? 1 : 0);
            if (mcnt < 0) mcnt = 0;
            if (mcnt > MAX) mcnt = MAX;
        end
        #1;
    endtask

    task automatic do_srst();
        clear_inputs();
        sync_rst = 1'b1;
        cycle();
        sync_rst = 1'b0;
    endtask

    initial begin
        int acc_n;
        async_rst = 1'b1;
        sync_rst = 1'b0;
        clear_inputs();
        sel = 8'hE4;
        adr = 64'h4444_3333_2222_1234;
        dat = 64'hD3D3_D2D2_D1D1_D0D0;
        tga = '0; tgc = '0; tgd = '0;
        tdat = 16'hBEEF; ttgd = 1'b1;
        model_reset();

        // reset without any clock edge
        #1;
        chk("rst_gnt", gnt_o, 4'b0000);
        chk("rst_cyc", t_cyc, 1'b0);
        chk("rst_stall", stall_o, 4'b1111);
        chk("rst_ack", ack_o, 4'b0000);
        @(posedge clk); #1;
        async_rst = 1'b0;
        cyc = 4'b0001;
        cycle();
        chk("first_gnt", gnt_o, 4'b0001);
        chk("first_adr", t_adr, 16'h1234);

        // fairness: each initiator does one access then drops cyc for one cycle
        do_srst();
        cyc = 4'b1111;
        cycle();
        for (int k = 0; k < 5; k++) begin
            chk("fair_gnt", gnt_o, 1 << (k % N));
            stb = 4'b0001 << (k % N);
            cycle();
            stb = '0; tack = 1'b1;
            cycle();
            tack = 1'b0;
            cyc = 4'b1111 & ~(4'b0001 << (k % N));
            cycle();
            cyc = 4'b1111;
        end

        // throttle at MAX outstanding
        do_srst();
        cyc = 4'b0100; stb = 4'b0100;
        cycle();
        acc_n = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (smp_acc) acc_n++;
        end
        chk("thr_accepts", acc_n, 4);
        chk("thr_stall", smp_stall[2], 1'b1);
        chk("thr_stb_full", smp_stb, 1'b0);
        tack = 1'b1;
        cycle();
        chk("thr_stb_ack", smp_stb, 1'b0);
        cycle();
        chk("thr_acc_ack", smp_acc, 1'b1);
        tack = 1'b0;
        cycle();
        chk("thr_refill", smp_acc, 1'b1);
        cycle();
        chk("thr_full_again", smp_stb, 1'b0);

        // lock holds the grant across a cyc gap
        do_srst();
        cyc = 4'b0010; lock = 4'b0010;
        cycle();
        cycle();
        cyc = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("lock_gnt", gnt_o, 4'b0010);
            chk("lock_cyc", smp_cyc, 1'b0);
            chk("lock_lock", smp_lock, 1'b1);
        end
        lock = '0;
        cycle();
        chk("lock_release", gnt_o, 4'b1000);

        // responses reach only the granted initiator
        do_srst();
        cyc = 4'b0001;
        cycle();
        tack = 1'b1;
        cycle();
        chk("iso_ack", smp_ack, 4'b0001);
        chk("iso_stall", smp_stall, 4'b1110);
        tack = 1'b0; terr = 1'b1;
        cycle();
        chk("iso_err", smp_err, 4'b0001);
        terr = 1'b0;

        // abort with outstanding accesses, then async reset mid-burst
        do_srst();
        cyc = 4'b0011; stb = 4'b0001;
        cycle();
        for (int k = 0; k < 3; k++) cycle();
        stb = '0; cyc = 4'b0010;
        cycle();
        chk("abort_gnt", gnt_o, 4'b0010);
        stb = 4'b0010;
        acc_n = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (smp_acc) acc_n++;
        end
        chk("abort_cnt_clear", acc_n, 4);
        #3 async_rst = 1'b1;
        #1;
        chk("arst_cyc", t_cyc, 1'b0);
        chk("arst_gnt", gnt_o, 4'b0000);
        chk("arst_stall", stall_o, 4'b1111);
        @(posedge clk); #1;
        async_rst = 1'b0;
        model_reset();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (cyc[i]) cyc[i] = ($urandom_range(0, 7) != 0);
                else        cyc[i] = ($urandom_range(0, 3) == 0);
                stb[i]  = cyc[i] & ($urandom_range(0, 2) != 0);
                lock[i] = ($urandom_range(0, 5) == 0);
                we[i]   = $urandom_range(0, 1);
            end
            adr = {$urandom, $urandom};
            dat = {$urandom, $urandom};
            sel = 8'($urandom);
            tdat = 16'($urandom);
            tstall = ($urandom_range(0, 3) == 0);
            tack = ($urandom_range(0, 2) == 0);
            terr = ($urandom_range(0, 15) == 0);
            trty = ($urandom_range(0, 15) == 0);
            sync_rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        sync_rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin arbiter sharing one pipelined Wishbone target between ITR_CNT initiators.
- Grant is held for a whole bus cycle (granted itr_cyc_i high) and also across cycles while the granted initiator holds itr_lock_i.
- A registered grant drives an AND-OR mux onto the target; target responses route back only to the granted initiator.
- An outstanding-access counter throttles pipelined requests to MAX_OUT.
- Sits between the initiator-side ports and any single target port in the bus fabric.

Parameters:
ITR_CNT, 4, number of initiators (≥2)
ADR_WIDTH, 16, address bus width
DAT_WIDTH, 16, data bus width
SEL_WIDTH, 2, select lines
TGA_WIDTH, 1, address tags
TGC_WIDTH, 1, cycle tags
TGRD_WIDTH, 1, read data tags
TGWD_WIDTH, 1, write data tags
MAX_OUT, 4, max unacknowledged accesses (1..15)

Ports:
clk_i  in  1  module clock
async_rst_i  in  1  asynchronous reset, active-high
sync_rst_i  in  1  synchronous reset, active-high
itr_cyc_i / itr_stb_i / itr_we_i / itr_lock_i  in  ITR_CNT each  per-initiator bus cycle, request, write enable, lock
itr_sel_i  in  ITR_CNT*SEL_WIDTH  selects, initiator n at slice n
itr_adr_i  in  ITR_CNT*ADR_WIDTH  addresses
itr_dat_i  in  ITR_CNT*DAT_WIDTH  write data
itr_tga_i / itr_tgc_i / itr_tgd_i  in  ITR_CNT*TGA/TGC/TGWD_WIDTH  tags
itr_ack_o / itr_err_o / itr_rty_o / itr_stall_o  out  ITR_CNT each  per-initiator responses
itr_dat_o  out  DAT_WIDTH  read data, broadcast
itr_tgd_o  out  TGRD_WIDTH  read data tags, broadcast
tgt_cyc_o / tgt_stb_o / tgt_we_o / tgt_lock_o  out  1  muxed target controls
tgt_sel_o / tgt_adr_o / tgt_dat_o / tgt_tga_o / tgt_tgc_o / tgt_tgd_o  out  matching widths  muxed target signals
tgt_ack_i / tgt_err_i / tgt_rty_i / tgt_stall_i  in  1  target responses
tgt_dat_i  in  DAT_WIDTH  read data
tgt_tgd_i  in  TGRD_WIDTH  read data tags
gnt_o  out  ITR_CNT  one-hot current grant (all zero when idle)

Behaviour:
- Reset: async_rst_i asynchronous, active-high; sync_rst_i acts identically at the clock edge.
  - gnt_reg=0; rr pointer=ITR_CNT-1, so initiator 0 has first priority; out_cnt=0.
  - All tgt_* outputs 0; itr_ack/err/rty_o=0; itr_stall_o all 1.
- Reset mid-operation: grant drops at once (async), tgt_cyc_o goes 0 in the same cycle, any outstanding count is discarded.
- States: IDLE (gnt_reg==0) and BUSY (one-hot gnt_reg).
- IDLE:
  - All itr_stall_o=1; tgt_* =0.
  - If any itr_cyc_i is high, gnt_reg <= first requester found searching ptr+1, ptr+2, … with wrap mod ITR_CNT; ptr <= that index.
  - Arbitration latency: one cycle from cyc to tgt_cyc_o.
- BUSY, granted index g:
  - All tgt_* outputs = initiator g's signals, combinationally.
  - itr_stall_o[g] = tgt_stall_i | (out_cnt==MAX_OUT).
  - itr_ack/err/rty_o[g] = tgt_*_i. Non-granted initiators: stall=1, responses 0.
  - When out_cnt==MAX_OUT, tgt_stb_o is forced 0.
- Counter:
  - Accept = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i. Resp = tgt_ack_i|tgt_err_i|tgt_rty_i.
  - out_cnt += accept - resp; accept and resp in the same cycle leave it unchanged.
  - Saturating guards: no decrement below 0 (a stray response is passed through and ignored by the counter); no increment beyond MAX_OUT.
- Release: at an edge where itr_cyc_i[g]==0 and itr_lock_i[g]==0, out_cnt<=0 and re-arbitration happens in the same edge.
  - Another pending cyc gives a back-to-back grant with no IDLE bubble; otherwise go to IDLE.
  - The pointer advances, so g has lowest priority next.
- Lock: if itr_cyc_i[g]==0 but itr_lock_i[g]==1, the grant is held; tgt_cyc_o=0 and tgt_lock_o=1 during the gap.
- Abort: cyc dropping with out_cnt>0 clears the counter. Responses arriving after the drop go to g only while g is still granted, otherwise nowhere.
- itr_dat_o/itr_tgd_o always equal tgt_dat_i/tgt_tgd_i.

Test Plan:
1. Reset: assert async_rst_i without a clock -> gnt_o=0, tgt_cyc_o=0, itr_stall_o=4'b1111. Release, raise itr_cyc_i=4'b0001 -> gnt_o=4'b0001 after 1 edge, tgt_adr_o = initiator 0 address.
2. Fairness: itr_cyc_i=4'b1111 held, each initiator does 1 access then drops cyc for 1 cycle -> grant order 0,1,2,3,0, back-to-back with no IDLE cycle between grants.
3. Throttle: MAX_OUT=4, target never stalls and ACKs late, 6 pipelined reads from initiator 2 -> exactly 4 accepted, then itr_stall_o[2]=1 and tgt_stb_o=0 until the first ack; out_cnt never exceeds 4. Same-cycle accept+ack keeps out_cnt constant.
4. Lock: initiator 1 does cyc, drops cyc with lock=1 for 3 cycles while initiator 3 requests -> gnt_o stays 4'b0010. On lock release, gnt_o=4'b1000 next edge.
5. Isolation: granted initiator 0, tgt_ack_i/err_i pulse -> only itr_ack_o[0]/itr_err_o[0] are set; the other initiators see stall=1, ack=0.
6. Abort: initiator 0 drops cyc with out_cnt=3 -> out_cnt=0 and the grant moves to the next requester on the same edge. Async reset mid-burst -> tgt_cyc_o=0 immediately.
